grant_burst_mux: RTL and testbench
==================================

Name: grant_burst_mux

Overview:
Downstream consumer of the 3-requester fixed-priority arbiter. It takes the arbiter's one-hot grants (g1..g3) and the per-requester data streams, and moves a fixed-length burst from the granted requester onto one shared, registered valid/ready output. After the last beat it pulses a per-requester done, so the requester drops its request and the arbiter returns to idle.

Parameters:
DATA_W, 8, width of each requester data bus and of out_data
BURST_LEN, 4, beats per grant; legal range 1..2**CNT_W
CNT_W, 3, beat counter width; must satisfy 2**CNT_W >= BURST_LEN

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
g1, g2, g3  input  1 each  grants from arbiter; expected one-hot or all zero
v1, v2, v3  input  1 each  requester i has a beat on di
d1, d2, d3  input  DATA_W each  requester data
rdy1, rdy2, rdy3  output  1 each  beat on di accepted this cycle (combinational)
done1, done2, done3  output  1 each  one-cycle pulse: burst for requester i complete
out_valid  output  1  out_data holds a beat
out_data  output  DATA_W  registered beat
out_src  output  2  source of current beat: 1, 2 or 3; 0 when idle
out_last  output  1  current beat is the final beat of a burst
out_ready  input  1  sink accepts beat when out_valid & out_ready
err_grant  output  1  sticky: more than one grant seen high in the same cycle

Behaviour:
- Reset (async): state=IDLE, beat_cnt=0, src=0. All outputs 0: out_valid, out_data, out_src, out_last, done*, err_grant. rdy* are 0 because state is IDLE.
- multi = two or more of g1..g3 high. Any cycle with multi sets err_grant; it clears only on reset.
- slot_free = ~out_valid | out_ready.
- IDLE:
  - rdy* = 0.
  - If exactly one grant is high: capture src (1/2/3), beat_cnt=0, go to XFER next cycle.
  - A multi condition never starts a burst.
- XFER:
  - rdy_src = g_src & ~multi & slot_free. Other rdy* = 0.
  - Accept = v_src & rdy_src. On accept at edge N, from edge N: out_data=d_src, out_src=src, out_valid=1, out_last=(beat_cnt==BURST_LEN-1), and beat_cnt increments.
  - On accepting the last beat: done_src=1 for exactly the next cycle, beat_cnt=0, go to RELEASE.
  - Abort: g_src low, or multi, in any XFER cycle. Go to IDLE, no done, beat_cnt=0.
    - Beats already in the output register still drain normally. out_last is never set for an aborted burst.
    - A grant switching directly to another source counts as an abort. The new source is captured from IDLE on the following cycle.
- RELEASE:
  - rdy* = 0.
  - Stay until g_src is low, then go to IDLE.
  - This blocks re-capture of the same, still-high grant before the arbiter sees the request drop.
- Output register:
  - out_valid & ~out_ready: out_data, out_src and out_last hold stable.
  - out_valid & out_ready with no new accept: out_valid=0 and out_last=0 next cycle; out_src=0.
  - Sink handshake and a new accept in the same cycle: the register reloads with no bubble.
- Throughput: one beat per cycle with out_ready=1 and v_src=1.
- Latency: 1 cycle from requester handshake to out_valid. Grant-to-first-rdy is 1 cycle (IDLE -> XFER).
- BURST_LEN=1: the first accept is also the last; out_last=1 and done pulses the next cycle.
- Reset mid-burst: immediate return to the reset values. The partial burst is lost; no done.

Test Plan:
- Reset: assert reset with g1=1 and v1=1 -> every output 0 while reset is high; first rdy1 one cycle after release.
- Full burst: BURST_LEN=4, g1=1, v1=1, out_ready=1, d1=0x11,0x12,0x13,0x14 ->
  - out_data 0x11..0x14 on consecutive cycles, out_src=1;
  - out_last=1 only with 0x14;
  - done1 pulses once the cycle after the 0x14 accept;
  - no rdy1 while g1 stays high after done.
- Backpressure: g2 burst, out_ready=0 for 3 cycles after the 2nd beat ->
  - out_data holds beat 2 and rdy2=0;
  - the remaining beats arrive in order with none lost or duplicated;
  - done2 after beat 4.
- Abort: g3 drops after 2 accepted beats -> no done3 and no out_last; a following g1 burst produces 4 beats with out_last on the 4th.
- Grant error: g1=g2=1 for one cycle in IDLE -> err_grant=1 and stays 1, no rdy*; it is cleared only by the next reset.
- Reset mid-operation: reset pulse during beat 3 of a g2 burst -> out_valid=0 and state IDLE immediately; no done2; after release with g2=1 a fresh 4-beat burst runs.

Source files
------------

// File: rtl/grant_burst_mux.sv
// Moves a fixed-length burst from the granted requester onto one registered valid/ready output.
// A done pulse after the final beat lets the requester drop its request.
module grant_burst_mux #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              g1,
  input  logic              g2,
  input  logic              g3,
  input  logic              v1,
  input  logic              v2,
  input  logic              v3,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic              rdy1,
  output logic              rdy2,
  output logic              rdy3,
  output logic              done1,
  output logic              done2,
  output logic              done3,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              out_last,
  input  logic              out_ready,
  output logic              err_grant
);

  typedef enum logic [1:0] {StIdle, StXfer, StRelease} state_e;

  state_e             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [1:0]         src;

  logic               multi;
  logic               any_grant;
  logic               slot_free;
  logic               g_src;
  logic               v_src;
  logic [DATA_W-1:0]  d_src;
  logic               rdy_src;
  logic               accept;
  logic               last_beat;
  logic [1:0]         cap_src;

  assign multi     = (g1 & g2) | (g1 & g3) | (g2 & g3);
  assign any_grant = g1 | g2 | g3;
  assign slot_free = ~out_valid | out_ready;
  assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign cap_src   = g1 ? 2'd1 : (g2 ? 2'd2 : 2'd3);

  always_comb begin
    g_src = 1'b0;
    v_src = 1'b0;
    d_src = '0;
    case (src)
      2'd1: begin g_src = g1; v_src = v1; d_src = d1; end
      2'd2: begin g_src = g2; v_src = v2; d_src = d2; end
      2'd3: begin g_src = g3; v_src = v3; d_src = d3; end
      default: ;
    endcase
  end

  assign rdy_src = (state == StXfer) & g_src & ~multi & slot_free;
  assign accept  = v_src & rdy_src;
  assign rdy1    = rdy_src & (src == 2'd1);
  assign rdy2    = rdy_src & (src == 2'd2);
  assign rdy3    = rdy_src & (src == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      beat_cnt  <= '0;
      src       <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      out_last  <= 1'b0;
      done1     <= 1'b0;
      done2     <= 1'b0;
      done3     <= 1'b0;
      err_grant <= 1'b0;
    end else begin
      err_grant <= err_grant | multi;
      done1     <= 1'b0;
      done2     <= 1'b0;
      done3     <= 1'b0;

      // Reload on accept even while draining, so back-to-back beats have no bubble.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= d_src;
        out_src   <= src;
        out_last  <= last_beat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_src   <= 2'd0;
        out_last  <= 1'b0;
      end

      case (state)
        StIdle: begin
          if (any_grant && !multi) begin
            src      <= cap_src;
            beat_cnt <= '0;
            state    <= StXfer;
          end
        end
        StXfer: begin
          if (!g_src || multi) begin
            beat_cnt <= '0;
            state    <= StIdle;
          end else if (accept) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= StRelease;
              done1    <= (src == 2'd1);
              done2    <= (src == 2'd2);
              done3    <= (src == 2'd3);
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        StRelease: begin
          // Hold off re-capture until the arbiter has seen the request drop.
          if (!g_src) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_grant_burst_mux.sv
// Randomized bench for grant_burst_mux against a burst-level reference model.
// Directed reset and full-burst sequences precede the random run.
module tb_grant_burst_mux;

  localparam int unsigned BL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       g1, g2, g3, v1, v2, v3;
  logic [7:0] d1, d2, d3;
  logic       rdy1, rdy2, rdy3, done1, done2, done3;
  logic       out_valid, out_last, out_ready, err_grant;
  logic [7:0] out_data;
  logic [1:0] out_src;

  always #5 clk = ~clk;

  grant_burst_mux #(.DATA_W(8), .BURST_LEN(BL), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .g1(g1), .g2(g2), .g3(g3),
    .v1(v1), .v2(v2), .v3(v3),
    .d1(d1), .d2(d2), .d3(d3),
    .rdy1(rdy1), .rdy2(rdy2), .rdy3(rdy3),
    .done1(done1), .done2(done2), .done3(done3),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_last(out_last), .out_ready(out_ready), .err_grant(err_grant)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how many beats it has moved, whether we wait for
  // its grant to drop, plus what the sink currently sees.
  int         owner;       // 0 = nobody
  int         beats;
  bit         moving;
  bit         wait_drop;
  bit         m_valid, m_last, m_err;
  logic [7:0] m_data;
  int         m_src;
  bit         m_done [1:3];

  task automatic model_reset();
    owner = 0; beats = 0; moving = 0; wait_drop = 0;
    m_valid = 0; m_last = 0; m_err = 0; m_data = 8'h00; m_src = 0;
    for (int k = 1; k <= 3; k++) m_done[k] = 0;
  endtask

  task automatic cycle(input logic [3:1] g, input logic [3:1] v, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c, input logic rdy,
                       input logic rst);
    logic [7:0] dd [1:3];
    bit         er [1:3];
    bit         nd [1:3];
    int         ng;
    bit         multi, free, acc;
    @(negedge clk);
    reset = rst; g1 = g[1]; g2 = g[2]; g3 = g[3];
    v1 = v[1]; v2 = v[2]; v3 = v[3];
    d1 = a; d2 = b; d3 = c; out_ready = rdy;
    dd[1] = a; dd[2] = b; dd[3] = c;
    if (rst) model_reset();
    #1;
    ng    = int'(g[1]) + int'(g[2]) + int'(g[3]);
    multi = (ng >= 2);
    free  = !m_valid || rdy;
    acc   = 0;
    for (int k = 1; k <= 3; k++) begin
      er[k] = !rst && moving && owner == k && g[k] && !multi && free;
      acc   = acc | (er[k] && v[k]);
      nd[k] = 0;
    end
    check("rdy1", 32'(rdy1), 32'(er[1]));
    check("rdy2", 32'(rdy2), 32'(er[2]));
    check("rdy3", 32'(rdy3), 32'(er[3]));
    check("done1", 32'(done1), 32'(m_done[1]));
    check("done2", 32'(done2), 32'(m_done[2]));
    check("done3", 32'(done3), 32'(m_done[3]));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_src", 32'(out_src), 32'(m_src));
    check("out_last", 32'(out_last), 32'(m_last));
    check("err_grant", 32'(err_grant), 32'(m_err));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_err = m_err | multi;
      if (acc) begin
        m_valid = 1; m_data = dd[owner]; m_src = owner; m_last = (beats == BL - 1);
      end else if (rdy) begin
        m_valid = 0; m_src = 0; m_last = 0;
      end
      if (moving) begin
        if (!g[owner] || multi) begin
          moving = 0; beats = 0;
        end else if (acc) begin
          beats++;
          if (beats == BL) begin
            nd[owner] = 1; beats = 0; moving = 0; wait_drop = 1;
          end
        end
      end else if (wait_drop) begin
        if (!g[owner]) wait_drop = 0;
      end else if (ng == 1) begin
        owner  = g[1] ? 1 : (g[2] ? 2 : 3);
        beats  = 0;
        moving = 1;
      end
      for (int k = 1; k <= 3; k++) m_done[k] = nd[k];
    end
  endtask

  initial begin
    logic [3:1] gs, vs;
    int         hold;
    int         r;
    reset = 1'b1; g1 = 0; g2 = 0; g3 = 0; v1 = 0; v2 = 0; v3 = 0;
    d1 = 0; d2 = 0; d3 = 0; out_ready = 0;
    model_reset();

    // Reset held with g1/v1 high, then a full burst from requester 1.
    for (int i = 0; i < 3; i++) cycle(3'b001, 3'b001, 8'h11, 8'h00, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      cycle(3'b001, 3'b001, 8'(8'h11 + i), 8'h00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

    // Requester 2 burst with a 3-cycle stall after the second beat.
    for (int i = 0; i < 10; i++)
      cycle(3'b010, 3'b010, 8'(8'h21 + i), 8'(8'h21 + i), 8'h00,
            (i >= 3 && i <= 5) ? 1'b0 : 1'b1, 1'b0);
    cycle(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

    // Double grant while idle sets the sticky error.
    cycle(3'b011, 3'b011, 8'h55, 8'h66, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

    hold = 0; gs = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 9);
        if (r <= 1)      gs = 3'b000;
        else if (r <= 8) gs = 3'(1 << $urandom_range(0, 2));
        else             gs = 3'(3'b111 & ~(1 << $urandom_range(0, 2)));
        hold = (r == 9) ? 1 : $urandom_range(1, 12);
      end
      hold--;
      for (int k = 1; k <= 3; k++) vs[k] = ($urandom_range(0, 4) != 0);
      cycle(gs, vs, 8'($urandom), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
